// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion: one schedule word per clock, emitted as 128-bit round keys
// over a valid/ready handshake. Define KEY_SCHED_IDX_EN to add the rk_idx/rk_last outputs.
module key_schedule_seq #(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [32*NK-1:0] key,
    output logic            busy,
    output logic [127:0]    rk,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic            done
`ifdef KEY_SCHED_IDX_EN
    ,
    output logic [3:0]      rk_idx,
    output logic            rk_last
`endif
);

    localparam int NR  = NK + 6;
    localparam int NRK = NR + 1;
    localparam logic [5:0] NK_C    = 6'(NK);
    localparam logic [5:0] LAST_I  = 6'(4 * NRK - 1);
    localparam logic [2:0] POS_MAX = 3'(NK - 1);

    generate
        if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
            $error("key_schedule_seq: NK must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GEN, HOLD, FIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   win_q [NK];
    logic [31:0]   win_d [NK];
    logic [31:0]   stg_q [4];
    logic [31:0]   stg_d [4];
    logic [5:0]    i_q, i_d;
    logic [2:0]    pos_q, pos_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          grp_full_q, grp_full_d;
    logic [127:0]  rk_q, rk_d;
    logic          rk_valid_q, rk_valid_d;
    logic          done_q, done_d;

    logic          accept, load, stall, last_on_rk;
    logic [31:0]   prev_w, old_w, sub_in, sub_out, new_w;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // The window always holds w[i-NK]..w[i-1]; during the first NK words it rotates the key
    // through itself, so it is aligned for the recurrence when i reaches NK.
    assign prev_w = win_q[NK-1];
    assign old_w  = win_q[0];
    assign sub_in = (pos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        new_w = old_w ^ prev_w;
        if (i_q < NK_C)
            new_w = old_w;
        else if (pos_q == 3'd0)
            new_w = old_w ^ sub_out ^ {rcon_q, 24'h0};
        else if (NK == 8 && pos_q == 3'd4)
            new_w = old_w ^ sub_out;
    end

    // A completed group waits in staging until rk is free or being accepted this cycle.
    assign accept = rk_valid_q & rk_ready;
    assign load   = grp_full_q & (~rk_valid_q | rk_ready);
    assign stall  = grp_full_q & rk_valid_q & ~rk_ready;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        stg_d      = stg_q;
        i_d        = i_q;
        pos_d      = pos_q;
        rcon_d     = rcon_q;
        grp_full_d = grp_full_q & ~load;
        rk_d       = rk_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;

        if (load) begin
            rk_d       = {stg_q[3], stg_q[2], stg_q[1], stg_q[0]};
            rk_valid_d = 1'b1;
        end else if (accept) begin
            rk_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < NK; k++)
                        win_d[k] = key[32*k +: 32];
                    i_d        = '0;
                    pos_d      = '0;
                    rcon_d     = 8'h01;
                    grp_full_d = 1'b0;
                    state_d    = GEN;
                end
            end
            GEN: begin
                if (stall) begin
                    state_d = HOLD;
                end else begin
                    for (int k = 0; k < NK - 1; k++)
                        win_d[k] = win_q[k+1];
                    win_d[NK-1]       = new_w;
                    stg_d[i_q[1:0]]   = new_w;
                    if (i_q[1:0] == 2'd3)
                        grp_full_d = 1'b1;
                    i_d   = i_q + 6'd1;
                    pos_d = (pos_q == POS_MAX) ? 3'd0 : pos_q + 3'd1;
                    if (i_q >= NK_C && pos_q == 3'd0)
                        rcon_d = xtime(rcon_q);
                    if (i_q == LAST_I)
                        state_d = FIN;
                end
            end
            HOLD: begin
                if (!stall)
                    state_d = GEN;
            end
            FIN: begin
                if (accept && last_on_rk) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            pos_q      <= '0;
            rcon_q     <= 8'h01;
            grp_full_q <= 1'b0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            pos_q      <= pos_d;
            rcon_q     <= rcon_d;
            grp_full_q <= grp_full_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

    // Window and staging are pure datapath; their contents are qualified by the FSM.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        stg_q <= stg_d;
    end

`ifdef KEY_SCHED_IDX_EN
    localparam logic [3:0] NR_C = 4'(NR);

    logic [3:0] rnd_q, rk_idx_q;
    logic       rk_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q     <= '0;
            rk_idx_q  <= '0;
            rk_last_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start)
                rnd_q <= '0;
            else if (load)
                rnd_q <= rnd_q + 4'd1;
            if (load) begin
                rk_idx_q  <= rnd_q;
                rk_last_q <= (rnd_q == NR_C);
            end else if (accept) begin
                rk_last_q <= 1'b0;
            end
        end
    end

    assign last_on_rk = rk_last_q;
    assign rk_idx     = rk_idx_q;
    assign rk_last    = rk_last_q;
`else
    assign last_on_rk = (state_q == FIN) && !grp_full_q;
`endif

    assign busy     = (state_q != IDLE);
    assign rk       = rk_q;
    assign rk_valid = rk_valid_q;
    assign done     = done_q;

endmodule

// AES forward S-box, combinational; byte x of the table sits at bits [2047-8x -: 8].
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] sel;

    assign sel   = ~{in_i, 3'b000};
    assign out_o = TBL[sel -: 8];

endmodule
